// File: rtl/simon_game_ctrl.sv
// Simon Says game sequencer: sequence LFSR, round/press tracking and display handshake.
// Optional INPUT_TIMEOUT_EN adds a per-press idle limit that ends the game in LOSE.
module simon_game_ctrl #(
    parameter logic [31:0] LFSR_SEED      = 32'hACE1_5EED,
    parameter logic [3:0]  MAX_ROUND      = 4'd15,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        btn_valid,
    input  logic [1:0]  btn_colour,
    input  logic        complete_display,
    output logic        rst_display,
    output logic        en_display,
    output logic [31:0] seq_out,
    output logic [3:0]  round_ctr,
    output logic [3:0]  input_idx,
    output logic        win,
    output logic        lose,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_SHOW    = 3'd2,
        S_WAIT_IN = 3'd3,
        S_WIN     = 3'd4,
        S_LOSE    = 3'd5
    } state_t;

    state_t      state;
    logic [31:0] lfsr;
    logic        lfsr_fb;
    logic [1:0]  exp_colour;

    // Taps 32,22,2,1 (bit indices 31,21,1,0).
    assign lfsr_fb    = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];
    assign exp_colour = seq_out[{input_idx, 1'b0} +: 2];
    assign state_o    = state;

`ifdef INPUT_TIMEOUT_EN
    logic [23:0] idle_ctr;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            lfsr        <= LFSR_SEED;
            rst_display <= 1'b1;
            en_display  <= 1'b0;
            seq_out     <= '0;
            round_ctr   <= '0;
            input_idx   <= '0;
            win         <= 1'b0;
            lose        <= 1'b0;
`ifdef INPUT_TIMEOUT_EN
            idle_ctr    <= '0;
`endif
        end else begin
            lfsr <= {lfsr[30:0], lfsr_fb};
            case (state)
                S_IDLE, S_WIN, S_LOSE: begin
                    rst_display <= 1'b1;
                    en_display  <= 1'b0;
                    if (start) begin
                        seq_out   <= lfsr;
                        round_ctr <= '0;
                        input_idx <= '0;
                        win       <= 1'b0;
                        lose      <= 1'b0;
                        state     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    rst_display <= 1'b0;
                    en_display  <= 1'b1;
                    state       <= S_SHOW;
                end
                S_SHOW: begin
                    rst_display <= 1'b0;
                    en_display  <= 1'b0;
                    // en_display marks the first SHOW cycle, where complete is stale.
                    if (!en_display && complete_display) begin
                        state     <= S_WAIT_IN;
                        input_idx <= '0;
`ifdef INPUT_TIMEOUT_EN
                        idle_ctr  <= '0;
`endif
                    end
                end
                S_WAIT_IN: begin
                    rst_display <= 1'b0;
                    en_display  <= 1'b0;
                    if (btn_valid) begin
`ifdef INPUT_TIMEOUT_EN
                        idle_ctr <= '0;
`endif
                        if (btn_colour != exp_colour) begin
                            state       <= S_LOSE;
                            lose        <= 1'b1;
                            rst_display <= 1'b1;
                        end else if (input_idx != round_ctr) begin
                            input_idx <= input_idx + 4'd1;
                        end else if (round_ctr == MAX_ROUND) begin
                            state       <= S_WIN;
                            win         <= 1'b1;
                            rst_display <= 1'b1;
                        end else begin
                            round_ctr   <= round_ctr + 4'd1;
                            input_idx   <= '0;
                            state       <= S_CLEAR;
                            rst_display <= 1'b1;
                        end
                    end
`ifdef INPUT_TIMEOUT_EN
                    else if (idle_ctr == TIMEOUT_CYCLES - 24'd1) begin
                        state       <= S_LOSE;
                        lose        <= 1'b1;
                        rst_display <= 1'b1;
                    end else begin
                        idle_ctr <= idle_ctr + 24'd1;
                    end
`endif
                end
                default: begin
                    state       <= S_IDLE;
                    rst_display <= 1'b1;
                    en_display  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Self-checking bench for simon_game_ctrl: directed flow with random timing and
// colour choices, checked against a round/press reference model.
module tb_simon_game_ctrl;

    localparam logic [31:0] SEED = 32'hACE1_5EED;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        btn_valid = 1'b0;
    logic [1:0]  btn_colour = 2'd0;
    logic        complete_display = 1'b0;
    logic        rst_display, en_display, win, lose;
    logic [31:0] seq_out;
    logic [3:0]  round_ctr, input_idx;
    logic [2:0]  state_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_lfsr;
    logic [31:0] exp_seq;
    logic [1:0]  colours [16];
    int          m_round, m_idx, m_state;

    always #5 clk = ~clk;

    simon_game_ctrl #(
        .LFSR_SEED(SEED),
        .MAX_ROUND(4'd15),
        .TIMEOUT_CYCLES(24'd8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .btn_valid(btn_valid),
        .btn_colour(btn_colour),
        .complete_display(complete_display),
        .rst_display(rst_display),
        .en_display(en_display),
        .seq_out(seq_out),
        .round_ctr(round_ctr),
        .input_idx(input_idx),
        .win(win),
        .lose(lose),
        .state_o(state_o)
    );

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    endfunction

    // Free-running reference LFSR: one step per clock while out of reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ".state"}, {29'd0, state_o}, m_state);
        chk({tag, ".round"}, {28'd0, round_ctr}, m_round);
        chk({tag, ".idx"}, {28'd0, input_idx}, m_idx);
        chk({tag, ".win"}, {31'd0, win}, (m_state == 4) ? 1 : 0);
        chk({tag, ".lose"}, {31'd0, lose}, (m_state == 5) ? 1 : 0);
    endtask

    task automatic do_start();
        @(negedge clk);
        start   = 1'b1;
        exp_seq = m_lfsr;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 16; i++) colours[i] = exp_seq[2*i +: 2];
        m_round = 0;
        m_idx   = 0;
        m_state = 1;
        chk("start.seq", seq_out, exp_seq);
        chk_status("start");
    endtask

    task automatic round_show(input int hold, input bit early);
        chk("clear.state", {29'd0, state_o}, 1);
        chk("clear.rst", {31'd0, rst_display}, 1);
        if (early) complete_display = 1'b1;
        @(negedge clk);
        chk("show1.state", {29'd0, state_o}, 2);
        chk("show1.en", {31'd0, en_display}, 1);
        chk("show1.rst", {31'd0, rst_display}, 0);
        @(negedge clk);
        chk("show2.state", {29'd0, state_o}, 2);
        chk("show2.en", {31'd0, en_display}, 0);
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("show.hold", {29'd0, state_o}, 2);
            end
            complete_display = 1'b1;
        end
        @(negedge clk);
        m_state = 3;
        m_idx   = 0;
        chk_status("wait_in");
        complete_display = 1'b0;
    endtask

    task automatic press(input logic [1:0] col);
        @(negedge clk);
        btn_valid  = 1'b1;
        btn_colour = col;
        @(negedge clk);
        btn_valid = 1'b0;
        if (m_state == 3) begin
            if (col != colours[m_idx])  m_state = 5;
            else if (m_idx < m_round)   m_idx++;
            else if (m_round == 15)     m_state = 4;
            else begin
                m_round++;
                m_idx   = 0;
                m_state = 1;
            end
        end
        chk_status("press");
    endtask

    task automatic play_round(input int hold);
        int r;
        r = m_round;
        for (int i = 0; i <= r; i++) press(colours[i]);
        if (m_state == 1) round_show(hold, m_round == 2);
    endtask

    initial begin
        m_round = 0; m_idx = 0; m_state = 0;
        repeat (3) @(negedge clk);
        chk("rst.seq", seq_out, 0);
        chk("rst.rst_display", {31'd0, rst_display}, 1);
        chk("rst.en_display", {31'd0, en_display}, 0);
        chk_status("rst");
        rst_n = 1'b1;

        press(2'($urandom));
        repeat ($urandom_range(1, 20)) @(negedge clk);
        do_start();
        round_show(10, 1'b0);

        // start is a no-op while playing
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("start_ignored.state", {29'd0, state_o}, 3);
        chk("start_ignored.seq", seq_out, exp_seq);

        // Full winning game through round 15
        while (m_state == 3) play_round($urandom_range(0, 3));
        chk("win.score", {28'd0, round_ctr}, 15);
        chk("win.flag", {31'd0, win}, 1);
        press(2'($urandom));
        repeat ($urandom_range(1, 5)) @(negedge clk);
        chk_status("win.hold");

        // Restart from WIN, lose on second colour of round 1
        do_start();
        round_show(2, 1'b0);
        play_round(1);
        press(colours[0]);
        press(colours[1] ^ 2'b01);
        chk("lose.flag", {31'd0, lose}, 1);
        chk("lose.score", {28'd0, round_ctr}, 1);
        chk("lose.rst_display", {31'd0, rst_display}, 1);

        // Restart from LOSE, lose at a random wrong colour in round 3
        do_start();
        round_show(0, 1'b0);
        while (m_round < 3) play_round($urandom_range(0, 2));
        press(colours[0]);
        press(colours[1]);
        press(colours[2] ^ 2'($urandom_range(1, 3)));
        chk("lose3.score", {28'd0, round_ctr}, 3);

`ifdef INPUT_TIMEOUT_EN
        do_start();
        round_show(0, 1'b0);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk("timeout.pending", {29'd0, state_o}, 3);
        end
        @(negedge clk);
        m_state = 5;
        chk_status("timeout.lose");

        do_start();
        round_show(0, 1'b0);
        repeat (6) @(negedge clk);
        press(colours[0]);
        round_show(0, 1'b0);
`endif

        // Asynchronous reset in the middle of WAIT_IN
        do_start();
        round_show(1, 1'b0);
        play_round(0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_round = 0; m_idx = 0; m_state = 0;
        chk_status("midrst");
        chk("midrst.seq", seq_out, 0);
        chk("midrst.rst_display", {31'd0, rst_display}, 1);
        chk("midrst.en_display", {31'd0, en_display}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat ($urandom_range(0, 7)) @(negedge clk);
        do_start();
        round_show(0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
